pll_lock_supervisor: RTL



---
 rtl/pll_sup_pkg.sv | 28 ++
 rtl/sync_bit.sv | 23 ++
 rtl/pll_lock_supervisor.sv | 110 +++++++++++
 3 files changed

// File: rtl/pll_sup_pkg.sv
// Shared state encoding and width helpers for the PLL lock supervisor.
// No logic of its own; zero latency.
// No flow control; constants and constant functions only.
package pll_sup_pkg;

    typedef enum logic [2:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        STABILIZE = 3'd2,
        RUN       = 3'd3,
        FAIL      = 3'd4
    } pll_state_t;

    // Bits needed to hold 0..value-1, never less than one.
    function automatic int clog2(input int value);
        int w;
        w = 1;
        while (((1 << w) < value) && (w < 31)) w++;
        return w;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_bit.sv
// Two-flop synchroniser for a single level signal, async active-high clear.
// Latency: two destination clock edges.
// No backpressure; samples every edge.
module sync_bit (
    input  logic clk,
    input  logic clr,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_supervisor.sv
// Sequences PLL reset, qualifies lock, and gates the downstream reset; retries or flags failure.
// Latency: lock rise to sys_rst release is 2 + STABLE_CYCLES + 1 edges; lock loss to reset is 3 edges.
// No backpressure; retry_clr is a one-cycle request honoured only in FAIL.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter  int RST_CYCLES    = 16,
    parameter  int LOCK_TIMEOUT  = 50000,
    parameter  int STABLE_CYCLES = 1024,
    parameter  int MAX_RETRY     = 3,
    parameter  int CNT_W         = 8,
    localparam int RTY_W         = clog2(MAX_RETRY + 1)
) (
    input  logic             clkin1,
    input  logic             rst,
    input  logic             pll_lock,
    input  logic             retry_clr,
    output logic             pll_rst,
    output logic             sys_rst,
    output logic             locked,
    output logic             fail,
    output logic [RTY_W-1:0] retry_cnt,
    output logic [CNT_W-1:0] loss_cnt
);

    localparam int TMR_W = clog2(max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES));
    localparam logic [TMR_W-1:0] RST_LAST = TMR_W'(RST_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(LOCK_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] STB_LAST = TMR_W'(STABLE_CYCLES - 1);
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);

    pll_state_t       state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [RTY_W-1:0] retry_d;
    logic [CNT_W-1:0] loss_d;
    logic             lock_s;

    sync_bit u_lock_sync (
        .clk (clkin1),
        .clr (rst),
        .d   (pll_lock),
        .q   (lock_s)
    );

    always_comb begin
        state_d = state_q;
        retry_d = retry_cnt;
        loss_d  = loss_cnt;
        case (state_q)
            RESET_PLL: begin
                if (tmr_q == RST_LAST) state_d = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                // Lock seen on the final timeout cycle still counts as lock.
                if (lock_s) begin
                    state_d = STABILIZE;
                end else if (tmr_q == TMO_LAST) begin
                    retry_d = retry_cnt + 1'b1;
                    state_d = (retry_d == RTY_MAX) ? FAIL : RESET_PLL;
                end
            end
            STABILIZE: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                end else if (tmr_q == STB_LAST) begin
                    state_d = RUN;
                    retry_d = '0;
                end
            end
            RUN: begin
                if (!lock_s) begin
                    if (loss_cnt != '1) loss_d = loss_cnt + 1'b1;
                    state_d = RESET_PLL;
                end
            end
            FAIL: begin
                if (retry_clr) begin
                    retry_d = '0;
                    state_d = RESET_PLL;
                end
            end
            default: state_d = RESET_PLL;
        endcase
        tmr_d = (state_d != state_q) ? '0 : tmr_q + 1'b1;
    end

    // Outputs decode the next state so they move on the edge that enters it.
    always_ff @(posedge clkin1 or posedge rst) begin
        if (rst) begin
            state_q   <= RESET_PLL;
            tmr_q     <= '0;
            retry_cnt <= '0;
            loss_cnt  <= '0;
            pll_rst   <= 1'b1;
            sys_rst   <= 1'b1;
            locked    <= 1'b0;
            fail      <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmr_q     <= tmr_d;
            retry_cnt <= retry_d;
            loss_cnt  <= loss_d;
            pll_rst   <= (state_d == RESET_PLL) || (state_d == FAIL);
            sys_rst   <= (state_d != RUN);
            locked    <= (state_d == RUN);
            fail      <= (state_d == FAIL);
        end
    end

endmodule
